// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: opcode encodings, default widths and the fetch FSM states.
package cpu_pkg;

    localparam int PC_WIDTH_DEF    = 15;
    localparam int INSTR_WIDTH_DEF = 24;

    localparam int OPC_MSB = 23;
    localparam int OPC_LSB = 20;

    localparam logic [3:0] OPC_NOP = 4'b1000;
    localparam logic [3:0] OPC_JMP = 4'b0111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_BUBBLE = 2'd2
    } fetch_state_e;

    function automatic logic is_nop(input logic [3:0] opc);
        return opc == OPC_NOP;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Registered-output synchronous FIFO with flush; push while full is legal only alongside pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: PC, fetch FSM, redirect flush and a small {pc, instr} queue towards decode.
// FETCH_NOP_SQUASH_EN drops NOP words before they are queued and counts them.
module instr_fetch_queue
    import cpu_pkg::*;
#(
    parameter int                  PC_WIDTH    = PC_WIDTH_DEF,
    parameter int                  INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter int                  FIFO_DEPTH  = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    localparam int                 CW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   mem_clk,
    input  logic                   mem_rst,
    input  logic                   fetch_en,
    output logic [PC_WIDTH-1:0]    fetch_pc,
    input  logic [INSTR_WIDTH-1:0] fetch_instr,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]    out_pc,
`ifdef FETCH_NOP_SQUASH_EN
    output logic [15:0]            nop_squash_cnt,
`endif
    output logic [CW-1:0]          q_count
);

    localparam int EW = PC_WIDTH + INSTR_WIDTH;

    fetch_state_e          state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic                  fetch_slot;
    logic                  redirect_armed;
    logic                  redirect_take;
    logic                  deq;
    logic                  fetch_ok;
    logic                  push;
    logic                  fifo_full;
    logic [EW-1:0]         head;

    always_ff @(posedge mem_clk or posedge mem_rst) begin
        if (mem_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_RUN;
            S_RUN:    state_d = redirect_take ? S_BUBBLE : S_RUN;
            S_BUBBLE: state_d = redirect_take ? S_BUBBLE : S_RUN;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fetch_slot     = 1'b0;
        redirect_armed = 1'b0;
        case (state_q)
            S_RUN: begin
                fetch_slot     = 1'b1;
                redirect_armed = 1'b1;
            end
            S_BUBBLE: redirect_armed = 1'b1;
            default: begin
                fetch_slot     = 1'b0;
                redirect_armed = 1'b0;
            end
        endcase
    end

    // A redirect beats every handshake, including a dequeue in the same cycle.
    assign redirect_take = redirect_valid && redirect_armed;
    assign fifo_full     = (q_count == CW'(FIFO_DEPTH));
    assign deq           = out_valid && out_ready && !redirect_valid;
    assign fetch_ok      = fetch_slot && fetch_en && !redirect_valid && (!fifo_full || deq);

`ifdef FETCH_NOP_SQUASH_EN
    logic        squash;
    logic [15:0] squash_cnt_q, squash_cnt_d;

    assign squash = fetch_ok && is_nop(fetch_instr[OPC_MSB:OPC_LSB]);
    assign push   = fetch_ok && !squash;

    always_comb begin
        squash_cnt_d = squash_cnt_q;
        if (squash && (squash_cnt_q != 16'hFFFF)) begin
            squash_cnt_d = squash_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge mem_clk or posedge mem_rst) begin
        if (mem_rst) begin
            squash_cnt_q <= '0;
        end else begin
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign nop_squash_cnt = squash_cnt_q;
`else
    assign push = fetch_ok;
`endif

    always_comb begin
        pc_d = pc_q;
        if (redirect_take) begin
            pc_d = redirect_pc;
        end else if (fetch_ok) begin
            pc_d = pc_q + PC_WIDTH'(1);
        end
    end

    always_ff @(posedge mem_clk or posedge mem_rst) begin
        if (mem_rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (mem_clk),
        .rst   (mem_rst),
        .push  (push),
        .pop   (deq),
        .flush (redirect_take),
        .wdata ({pc_q, fetch_instr}),
        .rdata (head),
        .count (q_count)
    );

    assign fetch_pc  = pc_q;
    assign out_valid = (q_count != '0);
    assign out_pc    = out_valid ? head[EW-1:INSTR_WIDTH] : '0;
    assign out_instr = out_valid ? head[INSTR_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue against a queue-based model of the fetch rules.
module tb_instr_fetch_queue;

    logic        mem_clk = 1'b0;
    logic        mem_rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic [14:0] fetch_pc;
    logic [23:0] fetch_instr;
    logic        redirect_valid = 1'b0;
    logic [14:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] out_instr;
    logic [14:0] out_pc;
    logic [2:0]  q_count;
`ifdef FETCH_NOP_SQUASH_EN
    logic [15:0] nop_squash_cnt;
`endif

    logic [23:0] mem [0:32767];
    assign fetch_instr = mem[fetch_pc];

    instr_fetch_queue dut (
        .mem_clk        (mem_clk),
        .mem_rst        (mem_rst),
        .fetch_en       (fetch_en),
        .fetch_pc       (fetch_pc),
        .fetch_instr    (fetch_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
`ifdef FETCH_NOP_SQUASH_EN
        .nop_squash_cnt (nop_squash_cnt),
`endif
        .q_count        (q_count)
    );

    always #5 mem_clk = ~mem_clk;

    typedef struct {
        logic [14:0] pc;
        logic [23:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [14:0] mpc;
    bit          started;
    bit          bubble;
    int          msq;
    int          n_checks = 0;
    int          n_fail = 0;

    // Model one clock edge from the inputs currently applied, then advance the DUT.
    task automatic step();
        bit   d, e, sq;
        ent_t en;
        if (!started) begin
            started = 1;
        end else if (redirect_valid) begin
            mq.delete();
            mpc    = redirect_pc;
            bubble = 1;
        end else begin
            d = (mq.size() != 0) && out_ready;
            e = !bubble && fetch_en && ((mq.size() < 4) || d);
            if (d) void'(mq.pop_front());
            if (e) begin
`ifdef FETCH_NOP_SQUASH_EN
                sq = (mem[mpc][23:20] == 4'b1000);
`else
                sq = 0;
`endif
                if (sq) begin
                    if (msq < 65535) msq++;
                end else begin
                    en.pc    = mpc;
                    en.instr = mem[mpc];
                    mq.push_back(en);
                end
                mpc = mpc + 15'd1;
            end
            bubble = 0;
        end
        @(posedge mem_clk);
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        mpc     = '0;
        started = 0;
        bubble  = 0;
        msq     = 0;
    endtask

    task automatic do_reset();
        mem_rst        = 1'b1;
        fetch_en       = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge mem_clk);
        #1;
        mem_rst = 1'b0;
    endtask

    task automatic fill_random_mem();
        for (int i = 0; i < 32768; i++) mem[i] = 24'($urandom);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (out_valid !== 1'b0 || q_count !== 3'd0 || out_pc !== 15'd0 || out_instr !== 24'd0 || fetch_pc !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%0b count=%0d pc=%0d instr=%h fetch_pc=%0d expected 0 0 0 0 0",
                     out_valid, q_count, out_pc, out_instr, fetch_pc);
        end
    endtask

    task automatic test_in_order();
        do_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || fetch_pc !== 15'd0) begin
            n_fail++;
            $display("FAIL idle_cycle: valid=%0b fetch_pc=%0d expected 0 0", out_valid, fetch_pc);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== 15'(i) || out_instr !== mem[i] || fetch_pc !== 15'(i + 1)) begin
                n_fail++;
                $display("FAIL in_order[%0d]: valid=%0b pc=%0d instr=%h fetch_pc=%0d expected 1 %0d %h %0d",
                         i, out_valid, out_pc, out_instr, fetch_pc, i, mem[i], i + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b0;
        repeat (7) step();
        n_checks++;
        if (q_count !== 3'd4 || fetch_pc !== 15'd4 || out_pc !== 15'd0) begin
            n_fail++;
            $display("FAIL fill_full: count=%0d fetch_pc=%0d head=%0d expected 4 4 0", q_count, fetch_pc, out_pc);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_pc !== 15'(i) || out_instr !== mem[i] || q_count !== 3'd4) begin
                n_fail++;
                $display("FAIL drain[%0d]: head=%0d instr=%h count=%0d expected %0d %h 4",
                         i, out_pc, out_instr, q_count, i, mem[i]);
            end
            step();
            n_checks++;
            if (fetch_pc !== 15'(5 + i)) begin
                n_fail++;
                $display("FAIL full_steady_pc[%0d]: fetch_pc=%0d expected %0d", i, fetch_pc, 5 + i);
            end
        end
        n_checks++;
        if (out_pc !== 15'd4 || out_instr !== mem[4]) begin
            n_fail++;
            $display("FAIL resume: head=%0d instr=%h expected 4 %h", out_pc, out_instr, mem[4]);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b0;
        repeat (3) step();
        n_checks++;
        if (q_count !== 3'd2) begin
            n_fail++;
            $display("FAIL pre_redirect_count: count=%0d expected 2", q_count);
        end
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 15'd3;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (q_count !== 3'd0 || out_valid !== 1'b0 || fetch_pc !== 15'd3) begin
            n_fail++;
            $display("FAIL redirect_flush: count=%0d valid=%0b fetch_pc=%0d expected 0 0 3", q_count, out_valid, fetch_pc);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0 || fetch_pc !== 15'd3) begin
            n_fail++;
            $display("FAIL bubble: valid=%0b fetch_pc=%0d expected 0 3", out_valid, fetch_pc);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 15'd3 || out_instr !== mem[3]) begin
            n_fail++;
            $display("FAIL after_bubble: valid=%0b pc=%0d instr=%h expected 1 3 %h", out_valid, out_pc, out_instr, mem[3]);
        end
    endtask

    task automatic test_wrap();
        fetch_en  = 1'b0;
        out_ready = 1'b1;
        repeat (6) step();
        n_checks++;
        if (out_valid !== 1'b0 || q_count !== 3'd0) begin
            n_fail++;
            $display("FAIL drain_empty: valid=%0b count=%0d expected 0 0", out_valid, q_count);
        end
        fetch_en       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 15'h7FFF;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 15'h7FFF || out_instr !== mem[32767]) begin
            n_fail++;
            $display("FAIL wrap_top: valid=%0b pc=%0d expected 1 32767", out_valid, out_pc);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 15'd0 || fetch_pc !== 15'd1) begin
            n_fail++;
            $display("FAIL wrap_zero: valid=%0b pc=%0d fetch_pc=%0d expected 1 0 1", out_valid, out_pc, fetch_pc);
        end
    endtask

`ifdef FETCH_NOP_SQUASH_EN
    task automatic test_nop_squash();
        int seen_other;
        int seen_one;
        mem[0] = 24'h800000;
        mem[1] = 24'hA00011;
        mem[2] = 24'h800000;
        do_reset();
        fetch_en   = 1'b1;
        out_ready  = 1'b1;
        seen_other = 0;
        seen_one   = 0;
        step();
        for (int i = 0; i < 6; i++) begin
            if (i == 3) fetch_en = 1'b0;
            step();
            if (out_valid) begin
                if (out_pc == 15'd1 && out_instr == 24'hA00011) seen_one++;
                else seen_other++;
            end
        end
        n_checks++;
        if (seen_one !== 1 || seen_other !== 0) begin
            n_fail++;
            $display("FAIL squash_output: pc1_seen=%0d other_seen=%0d expected 1 0", seen_one, seen_other);
        end
        n_checks++;
        if (nop_squash_cnt !== 16'd2 || fetch_pc !== 15'd3) begin
            n_fail++;
            $display("FAIL squash_count: cnt=%0d fetch_pc=%0d expected 2 3", nop_squash_cnt, fetch_pc);
        end
    endtask
`endif

    task automatic test_random();
        fill_random_mem();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            fetch_en       = ($urandom_range(0, 3) != 0);
            out_ready      = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? 15'(32764 + $urandom_range(0, 3)) : 15'($urandom);
            if (i == 400) begin
                mem_rst = 1'b1;
                #1;
                n_checks++;
                if (out_valid !== 1'b0 || q_count !== 3'd0 || fetch_pc !== 15'd0) begin
                    n_fail++;
                    $display("FAIL async_reset: valid=%0b count=%0d fetch_pc=%0d expected 0 0 0", out_valid, q_count, fetch_pc);
                end
                do_reset();
            end else begin
                step();
                n_checks++;
                if (out_valid !== (mq.size() != 0) || q_count !== 3'(mq.size()) || fetch_pc !== mpc) begin
                    n_fail++;
                    $display("FAIL random_ctrl[%0d]: valid=%0b count=%0d fetch_pc=%0d expected %0b %0d %0d",
                             i, out_valid, q_count, fetch_pc, mq.size() != 0, mq.size(), mpc);
                end else if (mq.size() != 0) begin
                    n_checks++;
                    if (out_pc !== mq[0].pc || out_instr !== mq[0].instr) begin
                        n_fail++;
                        $display("FAIL random_head[%0d]: pc=%0d instr=%h expected %0d %h",
                                 i, out_pc, out_instr, mq[0].pc, mq[0].instr);
                    end
                end
`ifdef FETCH_NOP_SQUASH_EN
                n_checks++;
                if (nop_squash_cnt !== 16'(msq)) begin
                    n_fail++;
                    $display("FAIL random_squash[%0d]: cnt=%0d expected %0d", i, nop_squash_cnt, msq);
                end
`endif
            end
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        fill_random_mem();
        model_reset();
        test_reset();
        test_in_order();
        test_backpressure();
        test_redirect();
        test_wrap();
`ifdef FETCH_NOP_SQUASH_EN
        test_nop_squash();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch stage directly upstream of decode/execute and of the memory block's instruction port.
- Drives the 15-bit instruction address and captures the 24-bit word returned combinationally in the same cycle.
- Buffers fetched {pc, instr} pairs in a small FIFO and presents them to decode through a valid/ready handshake.
- Accepts a redirect (JMP target) from execute that flushes the queue and reloads PC.

Parameters:
- PC_WIDTH, 15, instruction address width; PC wraps modulo 2^PC_WIDTH.
- INSTR_WIDTH, 24, instruction word width.
- FIFO_DEPTH, 4, queue entries; power of two, minimum 2.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- mem_clk  in  1  clock.
- mem_rst  in  1  asynchronous, active-high reset.
- fetch_en  in  1  level; when low, no new fetches are issued and the queue still drains.
- fetch_pc  out  PC_WIDTH  address to instruction memory.
- fetch_instr  in  INSTR_WIDTH  instruction word at fetch_pc, valid in the same cycle.
- redirect_valid  in  1  one-cycle pulse from execute requesting a jump.
- redirect_pc  in  PC_WIDTH  jump target, sampled when redirect_valid=1.
- out_valid  out  1  queue head is valid.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  INSTR_WIDTH  head instruction.
- out_pc  out  PC_WIDTH  address of the head instruction.
- q_count  out  clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, mem_rst=1): pc=RESET_PC, FSM=S_IDLE, count=0, rd/wr pointers=0.
  - out_valid=0, out_instr=0, out_pc=0, q_count=0, fetch_pc=RESET_PC.
- FSM states:
  - S_IDLE: one guaranteed cycle after reset release, so instruction memory contents are settled; no fetch. Goes to S_RUN.
  - S_RUN: normal fetching.
  - S_BUBBLE: one cycle after a redirect; no enqueue; goes to S_RUN. A redirect arriving in S_BUBBLE is honoured the same way.
- fetch_pc = pc register, always driven.
- Enqueue condition: state=S_RUN && fetch_en && !redirect_valid && (count<FIFO_DEPTH || deq).
  - On enqueue: write {pc, fetch_instr} at wr pointer; pc <= pc+1.
  - PC wraps from 2^PC_WIDTH-1 to 0; no overflow flag.
- Dequeue: deq = out_valid && out_ready && !redirect_valid. On deq, the rd pointer advances.
- Output timing:
  - out_valid = (count!=0); out_instr/out_pc come from the head entry (registered storage, no fall-through).
  - Latency from fetch to out_valid is 1 cycle into an empty queue.
- Count update: count <= count + enq - deq. Full with simultaneous deq still enqueues, so count stays at FIFO_DEPTH.
- Empty with out_ready=1: no effect.
- Redirect (any state except S_IDLE), next edge:
  - pc <= redirect_pc; count <= 0; pointers reset.
  - State <= S_BUBBLE; out_valid=0 the following cycle.
  - Any simultaneous out_ready handshake is discarded.
  - Redirect has priority over enqueue, dequeue and fetch_en.
- fetch_en low: pc holds; the queue drains normally; a redirect still applies.
- Reset mid-operation: everything returns to reset values immediately (asynchronously); in-flight entries are lost.
- Width rule: the PC increment is truncated to PC_WIDTH; redirect_pc is loaded as-is.

Optional Feature:
- Macro: FETCH_NOP_SQUASH_EN.
- Defined:
  - An instruction with fetch_instr[23:20]==4'b1000 (NOP) is not enqueued; pc still increments.
  - The FIFO never holds a NOP.
  - Adds output nop_squash_cnt, 16 bits: saturating count of squashed NOPs, reset to 0 and cleared by mem_rst only.
- Not defined: NOPs are enqueued like any instruction and the nop_squash_cnt port does not exist.

Decomposition:
- Shared package cpu_pkg:
  - OPC_NOP=4'b1000, OPC_JMP=4'b0111.
  - Opcode field position [23:20].
  - PC_WIDTH/INSTR_WIDTH defaults.
  - Fetch FSM state enum {S_IDLE, S_RUN, S_BUBBLE}.
- One sub-module: sync_fifo, parameterised width and depth.
  - Ports: clk, rst, push, pop, flush, data in/out, count.
  - The fetch top holds the PC, FSM, redirect priority and the squash logic.

Test Plan:
- Reset release, memory words 0..3 = A,B,C,D, out_ready=1, fetch_en=1:
  - S_IDLE for 1 cycle.
  - Then out_pc 0,1,2,3 on consecutive cycles with out_instr A,B,C,D; no gaps, no duplicates.
- out_ready=0 from reset, FIFO_DEPTH=4:
  - q_count reaches 4 and fetch_pc holds at 4.
  - Raise out_ready: entries pc 0..3 drain in order, then fetching resumes at pc 4.
- Queue full, out_ready=1 held: enqueue and dequeue in the same cycle; q_count stays 4; fetch_pc advances by 1 per cycle.
- Redirect with redirect_pc=3 while q_count=2 and out_ready=1:
  - Next cycle q_count=0, out_valid=0, fetch_pc=3.
  - One bubble cycle, then out_pc=3.
- PC wrap: redirect to 32767 with the queue empty → out_pc 32767 then 0.
- FETCH_NOP_SQUASH_EN defined, words 0..2 = 24'h800000, 24'hA00011, 24'h800000:
  - Only the pc=1 entry appears on the output.
  - nop_squash_cnt=2.
  - fetch_pc reaches 3.
